// File: rtl/rx_link_pkg.sv
// ============================================================================
// Module      : rx_link_pkg
// Description : Shared link-framing constants, state encoding and word decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_link_pkg;

    localparam logic [7:0] DEF_K_IDLE = 8'hBC;
    localparam logic [7:0] DEF_K_SOP  = 8'hFB;
    localparam logic [7:0] DEF_K_EOP  = 8'hFD;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_LEN   = 3'd1;
    localparam logic [2:0] ERR_SHORT = 3'd2;
    localparam logic [2:0] ERR_LONG  = 3'd3;
    localparam logic [2:0] ERR_CSUM  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_EOP  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        WC_IDLE  = 3'd0,
        WC_SOP   = 3'd1,
        WC_EOP   = 3'd2,
        WC_DATA  = 3'd3,
        WC_OTHER = 3'd4
    } wclass_t;

    function automatic wclass_t classify_word(
        input logic [31:0] data,
        input logic [3:0]  ctrl,
        input logic [7:0]  k_idle,
        input logic [7:0]  k_sop,
        input logic [7:0]  k_eop
    );
        wclass_t wc;
        wc = WC_OTHER;
        if (ctrl == 4'b0000) begin
            wc = WC_DATA;
        end else if (ctrl == 4'b0001) begin
            if (data[7:0] == k_idle)     wc = WC_IDLE;
            else if (data[7:0] == k_sop) wc = WC_SOP;
            else if (data[7:0] == k_eop) wc = WC_EOP;
        end
        return wc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_word_classify.sv
// ============================================================================
// Module      : rx_word_classify
// Description : Combinational word-class decode plus SOP header extraction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_word_classify
    import rx_link_pkg::*;
#(
    parameter int         MAX_LEN = 1024,
    parameter logic [7:0] K_IDLE  = DEF_K_IDLE,
    parameter logic [7:0] K_SOP   = DEF_K_SOP,
    parameter logic [7:0] K_EOP   = DEF_K_EOP
) (
    input  logic [31:0] data,
    input  logic [3:0]  ctrl,
    output wclass_t     wclass,
    output logic        hdr_valid,
    output logic [7:0]  hdr_type,
    output logic [15:0] hdr_len,
    output logic [15:0] eop_csum
);

    assign wclass    = classify_word(data, ctrl, K_IDLE, K_SOP, K_EOP);
    assign hdr_type  = data[15:8];
    assign hdr_len   = data[31:16];
    assign eop_csum  = data[23:8];
    // A header is only usable when its length lies in 1..MAX_LEN.
    assign hdr_valid = (wclass == WC_SOP) && (hdr_len != 16'd0) &&
                       (hdr_len <= 16'(MAX_LEN));

endmodule

`default_nettype wire

// File: rtl/rx_packet_parser.sv
// ============================================================================
// Module      : rx_packet_parser
// Description : Link framing parser: payload stream, packet status, counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_packet_parser
    import rx_link_pkg::*;
#(
    parameter int         MAX_LEN = 1024,
    parameter logic [7:0] K_IDLE  = DEF_K_IDLE,
    parameter logic [7:0] K_SOP   = DEF_K_SOP,
    parameter logic [7:0] K_EOP   = DEF_K_EOP
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [31:0] gt_rx_data,
    input  logic [3:0]  gt_rx_ctrl,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [7:0]  out_type,
    output logic [15:0] out_len,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic [31:0] pkt_cnt,
    output logic [31:0] err_cnt
);

    wclass_t     w_wclass;
    logic        w_hdr_valid;
    logic [7:0]  w_hdr_type;
    logic [15:0] w_hdr_len;
    logic [15:0] w_eop_csum;

    rx_word_classify #(
        .MAX_LEN (MAX_LEN),
        .K_IDLE  (K_IDLE),
        .K_SOP   (K_SOP),
        .K_EOP   (K_EOP)
    ) u_classify (
        .data      (gt_rx_data),
        .ctrl      (gt_rx_ctrl),
        .wclass    (w_wclass),
        .hdr_valid (w_hdr_valid),
        .hdr_type  (w_hdr_type),
        .hdr_len   (w_hdr_len),
        .eop_csum  (w_eop_csum)
    );

    state_t      r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic [15:0] r_csum, w_csum_n;
    logic [7:0]  r_type, w_type_n;
    logic [15:0] r_len, w_len_n;
    logic        r_valid, w_valid_n;
    logic [31:0] r_data, w_data_n;
    logic        r_sop, w_sop_n;
    logic        r_eop, w_eop_n;
    logic        r_done, w_done_n;
    logic        r_err, w_err_n;
    logic [2:0]  r_code, w_code_n;
    logic [31:0] r_pkt_cnt, r_err_cnt;
    logic        w_start;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_csum_n  = r_csum;
        w_type_n  = r_type;
        w_len_n   = r_len;
        w_valid_n = 1'b0;
        w_data_n  = r_data;
        w_sop_n   = 1'b0;
        w_eop_n   = 1'b0;
        w_done_n  = 1'b0;
        w_code_n  = ERR_OK;
        w_start   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_wclass == WC_SOP) begin
                    if (w_hdr_valid) begin
                        w_start = 1'b1;
                    end else begin
                        w_done_n = 1'b1;
                        w_code_n = ERR_LEN;
                    end
                end
            end
            S_DATA: begin
                if (w_wclass == WC_DATA) begin
                    w_valid_n = 1'b1;
                    w_data_n  = gt_rx_data;
                    w_sop_n   = (r_cnt == 16'd0);
                    w_eop_n   = (r_cnt == r_len - 16'd1);
                    w_csum_n  = r_csum + gt_rx_data[15:0] + gt_rx_data[31:16];
                    w_cnt_n   = r_cnt + 16'd1;
                    if (r_cnt == r_len - 16'd1) w_state_n = S_EOP;
                end else begin
                    // Any control word truncates; a valid SOP chains straight on.
                    w_done_n = 1'b1;
                    w_code_n = ERR_SHORT;
                    if (w_hdr_valid) w_start = 1'b1;
                    else             w_state_n = S_IDLE;
                end
            end
            S_EOP: begin
                w_done_n = 1'b1;
                case (w_wclass)
                    WC_EOP: begin
                        w_code_n  = (w_eop_csum == r_csum) ? ERR_OK : ERR_CSUM;
                        w_state_n = S_IDLE;
                    end
                    WC_DATA: begin
                        w_code_n  = ERR_LONG;
                        w_state_n = S_DROP;
                    end
                    default: begin
                        w_code_n = ERR_LONG;
                        if (w_hdr_valid) w_start = 1'b1;
                        else             w_state_n = S_IDLE;
                    end
                endcase
            end
            S_DROP: begin
                if (w_wclass == WC_EOP) w_state_n = S_IDLE;
                else if (w_hdr_valid)   w_start   = 1'b1;
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_start) begin
            w_type_n  = w_hdr_type;
            w_len_n   = w_hdr_len;
            w_cnt_n   = 16'd0;
            w_csum_n  = 16'd0;
            w_state_n = S_DATA;
        end
        w_err_n = w_done_n && (w_code_n != ERR_OK);
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_csum    <= 16'd0;
            r_type    <= 8'd0;
            r_len     <= 16'd0;
            r_valid   <= 1'b0;
            r_data    <= 32'd0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= ERR_OK;
            r_pkt_cnt <= 32'd0;
            r_err_cnt <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_csum  <= w_csum_n;
            r_type  <= w_type_n;
            r_len   <= w_len_n;
            r_valid <= w_valid_n;
            r_data  <= w_data_n;
            r_sop   <= w_sop_n;
            r_eop   <= w_eop_n;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            r_code  <= w_code_n;
            if (w_done_n && !w_err_n) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_done_n && w_err_n)  r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_type  = r_type;
    assign out_len   = r_len;
    assign pkt_done  = r_done;
    assign pkt_err   = r_err;
    assign err_code  = r_code;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rx_packet_parser.sv
// ============================================================================
// Module      : tb_rx_packet_parser
// Description : Directed vector bench for rx_packet_parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_packet_parser;

    logic        rx_clk = 1'b0;
    logic        rst;
    logic [31:0] gt_rx_data;
    logic [3:0]  gt_rx_ctrl;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_type;
    logic [15:0] out_len;
    logic        pkt_done;
    logic        pkt_err;
    logic [2:0]  err_code;
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;

    rx_packet_parser dut (
        .rx_clk     (rx_clk),
        .rst        (rst),
        .gt_rx_data (gt_rx_data),
        .gt_rx_ctrl (gt_rx_ctrl),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_type   (out_type),
        .out_len    (out_len),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        logic        r;
        logic [31:0] d;
        logic [3:0]  c;
        logic        v;
        logic        s;
        logic        e;
        logic        dn;
        logic [2:0]  code;
        logic [31:0] pc;
        logic [31:0] ec;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] W_IDLE = 32'h0000_00BC;

    function automatic logic [31:0] w_sop(input logic [7:0] t, input logic [15:0] l);
        return {l, t, 8'hFB};
    endfunction

    function automatic logic [31:0] w_eop(input logic [15:0] cs);
        return {8'h00, cs, 8'hFD};
    endfunction

    task automatic addv(input logic r, input logic [31:0] d, input logic [3:0] c,
                        input logic v, input logic s, input logic e, input logic dn,
                        input logic [2:0] code, input logic [31:0] pc, input logic [31:0] ec);
        vecs[nv] = '{r, d, c, v, s, e, dn, code, pc, ec};
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] d, input logic [3:0] c);
        @(negedge rx_clk);
        rst        = r;
        gt_rx_data = d;
        gt_rx_ctrl = c;
        @(posedge rx_clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        gt_rx_data = W_IDLE;
        gt_rx_ctrl = 4'b0001;
        repeat (2) @(posedge rx_clk);

        // Reset state
        addv(1, W_IDLE, 1, 0,0,0,0, 3'd0, 0, 0);
        // Good packet; checksum is the sum of both 16-bit halves of each word
        addv(0, w_sop(8'd8, 16'd4), 1, 0,0,0,0, 3'd0, 0, 0);
        addv(0, 32'h0101_0101, 0, 1,1,0,0, 3'd0, 0, 0);
        addv(0, 32'h0202_0202, 0, 1,0,0,0, 3'd0, 0, 0);
        addv(0, 32'h0303_0303, 0, 1,0,0,0, 3'd0, 0, 0);
        addv(0, 32'h0404_0404, 0, 1,0,1,0, 3'd0, 0, 0);
        addv(0, w_eop(16'h1414), 1, 0,0,0,1, 3'd0, 1, 0);
        addv(0, W_IDLE, 1, 0,0,0,0, 3'd0, 1, 0);
        // Checksum mismatch
        addv(0, w_sop(8'd8, 16'd4), 1, 0,0,0,0, 3'd0, 1, 0);
        addv(0, 32'h0101_0101, 0, 1,1,0,0, 3'd0, 1, 0);
        addv(0, 32'h0202_0202, 0, 1,0,0,0, 3'd0, 1, 0);
        addv(0, 32'h0303_0303, 0, 1,0,0,0, 3'd0, 1, 0);
        addv(0, 32'h0404_0404, 0, 1,0,1,0, 3'd0, 1, 0);
        addv(0, w_eop(16'h1415), 1, 0,0,0,1, 3'd4, 1, 1);
        // Short packet chained into a good one
        addv(0, w_sop(8'd8, 16'd4), 1, 0,0,0,0, 3'd0, 1, 1);
        addv(0, 32'h1111_2222, 0, 1,1,0,0, 3'd0, 1, 1);
        addv(0, 32'h3333_4444, 0, 1,0,0,0, 3'd0, 1, 1);
        addv(0, w_sop(8'd5, 16'd2), 1, 0,0,0,1, 3'd2, 1, 2);
        addv(0, 32'h0001_0002, 0, 1,1,0,0, 3'd0, 1, 2);
        addv(0, 32'h0003_0004, 0, 1,0,1,0, 3'd0, 1, 2);
        addv(0, w_eop(16'h000A), 1, 0,0,0,1, 3'd0, 2, 2);
        // Long packet: third word dropped, EOP returns to idle
        addv(0, w_sop(8'd1, 16'd2), 1, 0,0,0,0, 3'd0, 2, 2);
        addv(0, 32'h0000_0001, 0, 1,1,0,0, 3'd0, 2, 2);
        addv(0, 32'h0000_0002, 0, 1,0,1,0, 3'd0, 2, 2);
        addv(0, 32'h0000_0003, 0, 0,0,0,1, 3'd3, 2, 3);
        addv(0, w_eop(16'h0003), 1, 0,0,0,0, 3'd0, 2, 3);
        addv(0, 32'h0000_0009, 0, 0,0,0,0, 3'd0, 2, 3);
        // Length boundaries: 0, MAX_LEN+1, MAX_LEN (then truncated), 1
        addv(0, w_sop(8'd0, 16'd0), 1, 0,0,0,1, 3'd1, 2, 4);
        addv(0, w_sop(8'd0, 16'd1025), 1, 0,0,0,1, 3'd1, 2, 5);
        addv(0, w_sop(8'd0, 16'd1024), 1, 0,0,0,0, 3'd0, 2, 5);
        addv(0, W_IDLE, 1, 0,0,0,1, 3'd2, 2, 6);
        addv(0, w_sop(8'd0, 16'd1), 1, 0,0,0,0, 3'd0, 2, 6);
        addv(0, 32'h1234_5678, 0, 1,1,1,0, 3'd0, 2, 6);
        addv(0, w_eop(16'h68AC), 1, 0,0,0,1, 3'd0, 3, 6);
        // Reset mid-payload, stray data ignored, then a good packet
        addv(0, w_sop(8'd2, 16'd3), 1, 0,0,0,0, 3'd0, 3, 6);
        addv(0, 32'h0000_0011, 0, 1,1,0,0, 3'd0, 3, 6);
        addv(1, 32'h0000_0022, 0, 0,0,0,0, 3'd0, 0, 0);
        addv(0, 32'h0000_0033, 0, 0,0,0,0, 3'd0, 0, 0);
        addv(0, w_sop(8'd3, 16'd1), 1, 0,0,0,0, 3'd0, 0, 0);
        addv(0, 32'hAAAA_5555, 0, 1,1,1,0, 3'd0, 0, 0);
        addv(0, w_eop(16'hFFFF), 1, 0,0,0,1, 3'd0, 1, 0);

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].r, vecs[i].d, vecs[i].c);
            check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("v%0d sop", i), 32'(out_sop), 32'(vecs[i].s));
            check($sformatf("v%0d eop", i), 32'(out_eop), 32'(vecs[i].e));
            check($sformatf("v%0d done", i), 32'(pkt_done), 32'(vecs[i].dn));
            if (vecs[i].v)
                check($sformatf("v%0d data", i), out_data, vecs[i].d);
            if (vecs[i].dn) begin
                check($sformatf("v%0d err", i), 32'(pkt_err), 32'(vecs[i].code != 3'd0));
                check($sformatf("v%0d code", i), 32'(err_code), 32'(vecs[i].code));
            end
            check($sformatf("v%0d pkt_cnt", i), pkt_cnt, vecs[i].pc);
            check($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].ec);
        end

        // Header fields held across the packet; bounded wait for completion
        begin
            logic [31:0] pay [3];
            logic        seen;
            pay[0] = 32'h0000_0001;
            pay[1] = 32'h0000_0002;
            pay[2] = 32'h0000_0003;
            step(0, w_sop(8'h5A, 16'd3), 4'b0001);
            for (int k = 0; k < 3; k++) begin
                step(0, pay[k], 4'b0000);
                check($sformatf("hs type w%0d", k), 32'(out_type), 32'h5A);
                check($sformatf("hs len w%0d", k), 32'(out_len), 32'd3);
                check($sformatf("hs data w%0d", k), out_data, pay[k]);
            end
            step(0, w_eop(16'h0006), 4'b0001);
            seen = pkt_done;
            for (int k = 0; k < 8 && !seen; k++) begin
                step(0, W_IDLE, 4'b0001);
                seen = pkt_done;
            end
            check("hs done seen", 32'(seen), 32'd1);
            if (seen)
                check("hs code", 32'(err_code), 32'd0);
            check("hs type held", 32'(out_type), 32'h5A);
            check("hs pkt_cnt", pkt_cnt, 32'd2);
            check("hs err_cnt", err_cnt, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
